// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the Wishbone round-robin arbiter.
// The state encoding and counter widths live here so schedulers built on wb_rr_pick agree on them.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_ERR   = 2'd2
  } arb_state_e;

  localparam int WD_W   = 16;
  localparam int TCNT_W = 8;

  // Saturating increment for the abort counter: sticks at all-ones.
  function automatic logic [TCNT_W-1:0] sat_inc(input logic [TCNT_W-1:0] v);
    return (&v) ? v : v + TCNT_W'(1);
  endfunction

endpackage

// File: rtl/wb_rr_pick.sv
// Combinational round-robin selector: first set request scanning upward from last+1, wrapping.
// Works by rotating the request vector down, taking the lowest set bit, and rotating the pick back.
module wb_rr_pick #(
  parameter int NM = 2,
  parameter int LW = 1
) (
  input  logic [NM-1:0] req_i,
  input  logic [LW-1:0] last_i,
  output logic [NM-1:0] pick_o,
  output logic          vld_o
);

  localparam int SW = LW + 1;

  logic [SW-1:0] sh;
  logic [NM-1:0] rot;
  logic [NM-1:0] prot;

  always_comb begin
    // Shift of last+1 never exceeds NM, so a doubled vector covers every rotation.
    sh   = {1'b0, last_i} + SW'(1);
    rot  = NM'({req_i, req_i} >> sh);
    prot = '0;
    for (int p = NM - 1; p >= 0; p--) begin
      if (rot[p]) begin
        prot    = '0;
        prot[p] = 1'b1;
      end
    end
    pick_o = NM'(({prot, prot} << sh) >> NM);
    vld_o  = |req_i;
  end

endmodule

// File: rtl/wb_rr_arbiter.sv
// Round-robin Wishbone B4 classic arbiter: NM masters share one slave, grant held for a whole cyc.
// A watchdog aborts slave accesses that never ack with a one-cycle err and counts the aborts.
module wb_rr_arbiter #(
  parameter int NM      = 2,
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                 wb_clk_i,
  input  logic                 wb_rst_i,
  input  logic [NM-1:0]        m_cyc_i,
  input  logic [NM-1:0]        m_stb_i,
  input  logic [NM-1:0]        m_we_i,
  input  logic [NM*AW-1:0]     m_adr_i,
  input  logic [NM*DW-1:0]     m_dat_i,
  input  logic [NM*DW/8-1:0]   m_sel_i,
  output logic [NM-1:0]        m_ack_o,
  output logic [NM-1:0]        m_err_o,
  output logic [DW-1:0]        m_dat_o,
  output logic                 s_cyc_o,
  output logic                 s_stb_o,
  output logic                 s_we_o,
  output logic [AW-1:0]        s_adr_o,
  output logic [DW-1:0]        s_dat_o,
  output logic [DW/8-1:0]      s_sel_o,
  input  logic                 s_ack_i,
  input  logic [DW-1:0]        s_dat_i,
  output logic [NM-1:0]        grant_o,
  output logic [7:0]           timeout_cnt_o
);
  import wb_arb_pkg::*;

  localparam int LW  = (NM > 1) ? $clog2(NM) : 1;
  localparam int SLW = DW / 8;

  arb_state_e          state_q, state_d;
  logic [NM-1:0]       grant_q, grant_d;
  logic [LW-1:0]       last_q, last_d;
  logic [WD_W-1:0]     wd_q, wd_d;
  logic [TCNT_W-1:0]   tcnt_q, tcnt_d;

  logic [NM-1:0]       pick;
  logic                pick_vld;
  logic [LW-1:0]       pick_idx;

  logic                mx_cyc, mx_stb, mx_we;
  logic [AW-1:0]       mx_adr;
  logic [DW-1:0]       mx_dat;
  logic [SLW-1:0]      mx_sel;
  logic                wd_exp;

  wb_rr_pick #(
    .NM (NM),
    .LW (LW)
  ) u_pick (
    .req_i  (m_cyc_i),
    .last_i (last_q),
    .pick_o (pick),
    .vld_o  (pick_vld)
  );

  always_comb begin
    pick_idx = last_q;
    for (int k = 0; k < NM; k++) begin
      if (pick[k]) pick_idx = LW'(k);
    end
  end

  // Granted master's bus, selected by the one-hot grant (all zero when nobody owns the slave).
  always_comb begin
    mx_cyc = |(m_cyc_i & grant_q);
    mx_stb = |(m_stb_i & grant_q);
    mx_we  = |(m_we_i & grant_q);
    mx_adr = '0;
    mx_dat = '0;
    mx_sel = '0;
    for (int k = 0; k < NM; k++) begin
      if (grant_q[k]) begin
        mx_adr = m_adr_i[k*AW +: AW];
        mx_dat = m_dat_i[k*DW +: DW];
        mx_sel = m_sel_i[k*SLW +: SLW];
      end
    end
  end

  // An ack in the expiry cycle wins over the abort.
  assign wd_exp = mx_stb && !s_ack_i && (wd_q == WD_W'(TIMEOUT - 1));

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q <= ST_IDLE;
      grant_q <= '0;
      last_q  <= LW'(NM - 1);
      wd_q    <= '0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      wd_q    <= wd_d;
      tcnt_q  <= tcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    last_d  = last_q;
    wd_d    = wd_q;
    tcnt_d  = tcnt_q;
    unique case (state_q)
      ST_IDLE: begin
        wd_d = '0;
        if (pick_vld) begin
          grant_d = pick;
          last_d  = pick_idx;
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (s_ack_i)     wd_d = '0;
        else if (mx_stb) wd_d = wd_q + WD_W'(1);
        if (!mx_cyc) begin
          grant_d = '0;
          state_d = ST_IDLE;
        end else if (wd_exp) begin
          state_d = ST_ERR;
        end
      end
      ST_ERR: begin
        // Release unconditionally; a master still holding cyc is re-arbitrated.
        tcnt_d  = sat_inc(tcnt_q);
        wd_d    = '0;
        grant_d = '0;
        state_d = ST_IDLE;
      end
      default: begin
        grant_d = '0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    s_cyc_o = 1'b0;
    s_stb_o = 1'b0;
    s_we_o  = 1'b0;
    s_adr_o = '0;
    s_dat_o = '0;
    s_sel_o = '0;
    m_ack_o = '0;
    m_err_o = '0;
    if (state_q == ST_GRANT) begin
      s_cyc_o = mx_cyc;
      s_stb_o = mx_stb;
      s_we_o  = mx_we;
      s_adr_o = mx_adr;
      s_dat_o = mx_dat;
      s_sel_o = mx_sel;
      m_ack_o = grant_q & {NM{s_ack_i}};
    end else if (state_q == ST_ERR) begin
      m_err_o = grant_q;
    end
  end

  assign m_dat_o       = s_dat_i;
  assign grant_o       = grant_q;
  assign timeout_cnt_o = tcnt_q;

endmodule
